// File: rtl/iter_muldiv_pkg.sv
// Shared opcode encodings, flag bit positions and FSM encoding for the
// iterative multiply/divide unit that sits beside the ALU.
package iter_muldiv_pkg;

   localparam int OPCODE_WIDTH = 6;

   // Opcode encodings shared with the ALU decoder
   localparam logic [5:0] OP_MUL   = 6'h20;
   localparam logic [5:0] OP_MLA   = 6'h21;
   localparam logic [5:0] OP_MLS   = 6'h22;
   localparam logic [5:0] OP_UMULL = 6'h23;
   localparam logic [5:0] OP_UMLAL = 6'h24;
   localparam logic [5:0] OP_SMULL = 6'h25;
   localparam logic [5:0] OP_SMLAL = 6'h26;
   localparam logic [5:0] OP_UDIV  = 6'h27;
   localparam logic [5:0] OP_SDIV  = 6'h28;

   localparam int FLAG_SAT   = 4;
   localparam int FLAG_NEG   = 3;
   localparam int FLAG_ZERO  = 2;
   localparam int FLAG_CARRY = 1;
   localparam int FLAG_OVF   = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FIXUP = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic valid;
      logic is_div;
      logic is_signed;
      logic is_long;
      logic add_acc;
      logic sub_acc;
   } op_dec_t;

   // Saturation and carry are never produced by this unit.
   function automatic logic [4:0] make_flags(input logic neg, input logic zero, input logic ovf);
      logic [4:0] f;
      f             = '0;
      f[FLAG_SAT]   = 1'b0;
      f[FLAG_NEG]   = neg;
      f[FLAG_ZERO]  = zero;
      f[FLAG_CARRY] = 1'b0;
      f[FLAG_OVF]   = ovf;
      return f;
   endfunction

endpackage

// File: rtl/iter_muldiv_dp.sv
// Datapath of the iterative multiply/divide unit: operand capture with sign
// magnitude conversion, one shift-add / restoring-divide step per cycle, result fixup.
module iter_muldiv_dp
   import iter_muldiv_pkg::*;
#(
   parameter int DATA_WIDTH       = 32,
   parameter int ALUCONTROL_WIDTH = OPCODE_WIDTH
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          load,
   input  logic                          step,
   input  logic                          finish,
   input  logic [ALUCONTROL_WIDTH-1:0]   op,
   input  logic [DATA_WIDTH-1:0]         a,
   input  logic [DATA_WIDTH-1:0]         b,
   input  logic [2*DATA_WIDTH-1:0]       acc,
   output logic                          skip_run,
   output logic [2*DATA_WIDTH-1:0]       result,
   output logic [4:0]                    flags
);

   localparam int W = DATA_WIDTH;
   localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};

   op_dec_t dec_in;

   always_comb begin
      dec_in = '0;
      case (op)
         ALUCONTROL_WIDTH'(OP_MUL):   dec_in = '{valid: 1'b1, default: 1'b0};
         ALUCONTROL_WIDTH'(OP_MLA):   dec_in = '{valid: 1'b1, add_acc: 1'b1, default: 1'b0};
         ALUCONTROL_WIDTH'(OP_MLS):   dec_in = '{valid: 1'b1, sub_acc: 1'b1, default: 1'b0};
         ALUCONTROL_WIDTH'(OP_UMULL): dec_in = '{valid: 1'b1, is_long: 1'b1, default: 1'b0};
         ALUCONTROL_WIDTH'(OP_UMLAL): dec_in = '{valid: 1'b1, is_long: 1'b1, add_acc: 1'b1, default: 1'b0};
         ALUCONTROL_WIDTH'(OP_SMULL): dec_in = '{valid: 1'b1, is_long: 1'b1, is_signed: 1'b1, default: 1'b0};
         ALUCONTROL_WIDTH'(OP_SMLAL): dec_in = '{valid: 1'b1, is_long: 1'b1, is_signed: 1'b1,
                                                 add_acc: 1'b1, default: 1'b0};
         ALUCONTROL_WIDTH'(OP_UDIV):  dec_in = '{valid: 1'b1, is_div: 1'b1, default: 1'b0};
         ALUCONTROL_WIDTH'(OP_SDIV):  dec_in = '{valid: 1'b1, is_div: 1'b1, is_signed: 1'b1, default: 1'b0};
         default:                     dec_in = '0;
      endcase
   end

   // Unsupported ops and divide-by-zero bypass the iteration and produce zero.
   assign skip_run = !dec_in.valid || (dec_in.is_div && (b == '0));

   logic [W-1:0] mag_a, mag_b;
   assign mag_a = (dec_in.is_signed && a[W-1]) ? -a : a;
   assign mag_b = (dec_in.is_signed && b[W-1]) ? -b : b;

   logic           div_q, long_q, add_q, sub_q, skip_q, neg_q, ovf_q;
   logic [W-1:0]   opnd_q, hi_q, lo_q;
   logic [2*W-1:0] acc_q;

   // Multiply: hi:lo holds partial product over the shifting multiplier.
   // Divide:   hi is the partial remainder, lo shifts dividend out and quotient in.
   logic [W:0] mul_sum, div_shift, div_diff;
   logic       div_ge;

   assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
   assign div_shift = {hi_q, lo_q[W-1]};
   assign div_diff  = div_shift - {1'b0, opnd_q};
   assign div_ge    = !div_diff[W];

   logic [2*W-1:0] prod, prod_s, long_res, res_next;
   logic [W-1:0]   quo, short_res;
   logic [4:0]     flags_next;

   always_comb begin
      prod     = {hi_q, lo_q};
      prod_s   = neg_q ? -prod : prod;
      long_res = prod_s + (add_q ? acc_q : '0);
      quo      = neg_q ? -lo_q : lo_q;
      if (add_q)      short_res = lo_q + acc_q[W-1:0];
      else if (sub_q) short_res = acc_q[W-1:0] - lo_q;
      else            short_res = lo_q;

      if (skip_q)      res_next = '0;
      else if (div_q)  res_next = {{W{1'b0}}, quo};
      else if (long_q) res_next = long_res;
      else             res_next = {{W{1'b0}}, short_res};

      flags_next = make_flags(long_q ? res_next[2*W-1] : res_next[W-1],
                              res_next == '0,
                              ovf_q && !skip_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q  <= 1'b0;
         long_q <= 1'b0;
         add_q  <= 1'b0;
         sub_q  <= 1'b0;
         skip_q <= 1'b0;
         neg_q  <= 1'b0;
         ovf_q  <= 1'b0;
         opnd_q <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         acc_q  <= '0;
         result <= '0;
         flags  <= '0;
      end else begin
         if (load) begin
            div_q  <= dec_in.is_div;
            long_q <= dec_in.is_long;
            add_q  <= dec_in.add_acc;
            sub_q  <= dec_in.sub_acc;
            skip_q <= skip_run;
            neg_q  <= dec_in.is_signed && (a[W-1] ^ b[W-1]);
            ovf_q  <= dec_in.is_div && dec_in.is_signed && (a == INT_MIN) && (b == '1);
            opnd_q <= dec_in.is_div ? mag_b : mag_a;
            lo_q   <= dec_in.is_div ? mag_a : mag_b;
            hi_q   <= '0;
            acc_q  <= acc;
         end else if (step) begin
            if (div_q) begin
               hi_q <= div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
               lo_q <= {lo_q[W-2:0], div_ge};
            end else begin
               hi_q <= mul_sum[W:1];
               lo_q <= {mul_sum[0], lo_q[W-1:1]};
            end
         end
         if (finish) begin
            result <= res_next;
            flags  <= flags_next;
         end
      end
   end

endmodule

// File: rtl/iter_muldiv.sv
// Multi-cycle multiply/divide unit with valid/ready handshakes; this file holds
// the sequencing FSM and the iteration down-counter.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | in_ready high, waiting for an operation
//   ST_RUN   | one multiply/divide step per cycle, DATA_WIDTH cycles
//   ST_FIXUP | sign correction, accumulate, flags; result registered
//   ST_DONE  | out_valid high until out_ready
module iter_muldiv
   import iter_muldiv_pkg::*;
#(
   parameter int DATA_WIDTH       = 32,
   parameter int ALUCONTROL_WIDTH = OPCODE_WIDTH
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [ALUCONTROL_WIDTH-1:0]   op,
   input  logic [DATA_WIDTH-1:0]         a,
   input  logic [DATA_WIDTH-1:0]         b,
   input  logic [2*DATA_WIDTH-1:0]       acc,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [2*DATA_WIDTH-1:0]       result,
   output logic [4:0]                    flags
);

   localparam int CNT_W = $clog2(DATA_WIDTH);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             load, step, finish, skip_run;

   assign load   = (state == ST_IDLE)  && in_valid && !flush;
   assign step   = (state == ST_RUN)   && !flush;
   assign finish = (state == ST_FIXUP) && !flush;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else if (flush) begin
         // result/flags stay put; only the handshake state is abandoned
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  cnt      <= CNT_W'(DATA_WIDTH - 1);
                  state    <= skip_run ? ST_FIXUP : ST_RUN;
               end
            end
            ST_RUN: begin
               if (cnt == '0) state <= ST_FIXUP;
               else           cnt   <= cnt - 1'b1;
            end
            ST_FIXUP: begin
               state     <= ST_DONE;
               out_valid <= 1'b1;
            end
            ST_DONE: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   iter_muldiv_dp #(
      .DATA_WIDTH       (DATA_WIDTH),
      .ALUCONTROL_WIDTH (ALUCONTROL_WIDTH)
   ) u_dp (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (load),
      .step     (step),
      .finish   (finish),
      .op       (op),
      .a        (a),
      .b        (b),
      .acc      (acc),
      .skip_run (skip_run),
      .result   (result),
      .flags    (flags)
   );

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed bench for iter_muldiv: hand-computed products, quotients, flags,
// latencies, stalls, flush and asynchronous reset.
module tb_iter_muldiv;
   import iter_muldiv_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [5:0]    op;
   logic [W-1:0]  a, b;
   logic [2*W-1:0] acc, result;
   logic [4:0]    flags;

   int n_total = 0;
   int n_pass  = 0;

   localparam logic [4:0] F_NONE = 5'b00000;
   localparam logic [4:0] F_NEG  = 5'b01000;
   localparam logic [4:0] F_ZERO = 5'b00100;
   localparam logic [4:0] F_NOVF = 5'b01001;

   always #5 clk = ~clk;

   iter_muldiv #(.DATA_WIDTH(W), .ALUCONTROL_WIDTH(6)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .acc       (acc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic issue(input logic [5:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [2*W-1:0] cc);
      op = o; a = aa; b = bb; acc = cc; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = '0; b = '0; acc = '0;
   endtask

   // hold = cycles out_ready stays low after out_valid is first seen
   task automatic run_op(input string tag, input logic [5:0] o, input logic [W-1:0] aa,
                         input logic [W-1:0] bb, input logic [2*W-1:0] cc,
                         input logic [2*W-1:0] exp_res, input logic [4:0] exp_flags,
                         input int exp_lat, input int hold);
      int lat;
      issue(o, aa, bb, cc);
      lat = 1;
      chk({tag, "_busy"}, 64'(in_ready), 64'd0);
      while (!out_valid && lat < 200) begin
         tick();
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_res"}, result, exp_res);
      chk({tag, "_flags"}, 64'(flags), 64'(exp_flags));
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, "_hold_res"}, result, exp_res);
         chk({tag, "_hold_flags"}, 64'(flags), 64'(exp_flags));
         chk({tag, "_hold_rdy"}, 64'({in_ready, out_valid}), 64'b01);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_ack"}, 64'({in_ready, out_valid}), 64'b10);
   endtask

   initial begin
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op = '0; a = '0; b = '0; acc = '0;
      tick();
      tick();
      chk("reset_rdy", 64'({in_ready, out_valid}), 64'b10);
      chk("reset_res", result, 64'd0);
      chk("reset_flags", 64'(flags), 64'd0);
      reset_n = 1'b1;
      tick();

      run_op("umull_max", OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0,
             64'hFFFF_FFFE_0000_0001, F_NEG, W + 2, 0);
      run_op("smull_neg", OP_SMULL, 32'hFFFF_FFFD, 32'd7, 64'd0,
             64'hFFFF_FFFF_FFFF_FFEB, F_NEG, W + 2, 0);
      run_op("mls", OP_MLS, 32'd3, 32'd4, 64'd10,
             64'h0000_0000_FFFF_FFFE, F_NEG, W + 2, 0);
      run_op("sdiv_m7_2", OP_SDIV, 32'hFFFF_FFF9, 32'd2, 64'd0,
             64'h0000_0000_FFFF_FFFD, F_NEG, W + 2, 0);
      run_op("sdiv_ovf", OP_SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0,
             64'h0000_0000_8000_0000, F_NOVF, W + 2, 0);
      run_op("udiv_by0", OP_UDIV, 32'd5, 32'd0, 64'd0, 64'd0, F_ZERO, 2, 1);
      run_op("mul_stall", OP_MUL, 32'h0001_0000, 32'h0001_0000, 64'd0, 64'd0, F_ZERO, W + 2, 5);
      run_op("mla", OP_MLA, 32'd5, 32'd6, 64'hFFFF_FFFF_0000_0007, 64'h25, F_NONE, W + 2, 0);
      run_op("umlal_wrap", OP_UMLAL, 32'd2, 32'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, F_NONE, W + 2, 0);
      run_op("smlal", OP_SMLAL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0001_0000_0000,
             64'h0000_0001_0000_0001, F_NONE, W + 2, 0);
      run_op("udiv_100_7", OP_UDIV, 32'd100, 32'd7, 64'd0, 64'd14, F_NONE, W + 2, 0);
      run_op("udiv_max_1", OP_UDIV, 32'hFFFF_FFFF, 32'd1, 64'd0, 64'hFFFF_FFFF, F_NEG, W + 2, 0);
      run_op("sdiv_7_m2", OP_SDIV, 32'd7, 32'hFFFF_FFFE, 64'd0,
             64'h0000_0000_FFFF_FFFD, F_NEG, W + 2, 0);
      run_op("unsupported", 6'h3F, 32'd9, 32'd9, 64'd0, 64'd0, F_ZERO, 2, 0);
      run_op("mul_last", OP_MUL, 32'd6, 32'd7, 64'd0, 64'd42, F_NONE, W + 2, 0);

      // flush at T+10 of a long op
      issue(OP_UMULL, 32'd3, 32'd3, 64'd0);
      for (int i = 0; i < 9; i++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_rdy", 64'({in_ready, out_valid}), 64'b10);
      begin
         logic seen_valid;
         seen_valid = 1'b0;
         for (int i = 0; i < W + 8; i++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
         end
         chk("flush_no_valid", 64'(seen_valid), 64'd0);
      end
      chk("flush_res_held", result, 64'd42);
      chk("flush_flags_held", 64'(flags), 64'(F_NONE));

      // flush coincident with in_valid must not accept
      op = OP_MUL; a = 32'd2; b = 32'd2; in_valid = 1'b1; flush = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b0;
      tick();
      tick();
      chk("flush_accept", 64'({in_ready, out_valid}), 64'b10);

      // asynchronous reset in the middle of RUN
      issue(OP_UMULL, 32'hFFFF_FFFF, 32'd2, 64'd0);
      for (int i = 0; i < 5; i++) tick();
      chk("pre_reset_busy", 64'(in_ready), 64'd0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_rdy", 64'({in_ready, out_valid}), 64'b10);
      chk("midrst_res", result, 64'd0);
      chk("midrst_flags", 64'(flags), 64'd0);
      tick();
      reset_n = 1'b1;
      tick();
      run_op("after_reset", OP_SMULL, 32'hFFFF_FFFF, 32'd5, 64'd0,
             64'hFFFF_FFFF_FFFF_FFFB, F_NEG, W + 2, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time budget exhausted");
      $fatal(1, "timeout");
   end

endmodule
